// File: rtl/ccff_bitstream_loader_if.sv
// ccff_bitstream_loader_if: valid/ready word stream feeding the config-chain loader
interface ccff_bitstream_loader_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] cfg_word;
  logic cfg_valid;
  logic cfg_ready;
  modport master(output cfg_word, cfg_valid, input cfg_ready);
  modport slave(input cfg_word, cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serializes a word stream onto the config chain and monitors its tail
module ccff_bitstream_loader #(
  parameter int WORD_W = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W = 16
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic start,
  ccff_bitstream_loader_if.slave cfg,
  input  logic ccff_tail,
  output logic ccff_head,
  output logic chain_clk_en,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] tail_ones
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int PAD = NWORDS * WORD_W - CHAIN_LEN;
  localparam int SW = $clog2(WORD_W + 1);
  localparam logic [SW-1:0] FIRST_CNT = SW'(WORD_W - PAD);
  localparam logic [SW-1:0] FULL_CNT = SW'(WORD_W);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_d;
  logic [WORD_W-1:0] sr;
  logic [SW-1:0] sr_cnt;
  logic [CNT_W-1:0] words_left, bits_left;
  logic take, first;
  always_comb begin
    busy = state == LOAD;
    done = state == DONE;
    ccff_head = sr[WORD_W-1];
    chain_clk_en = busy && sr_cnt != '0;
    cfg.cfg_ready = busy && words_left != '0 && sr_cnt < SW'(2);
    take = cfg.cfg_valid && cfg.cfg_ready;
    first = words_left == CNT_W'(NWORDS);
    state_d = (!busy && start) ? LOAD : (chain_clk_en && bits_left == CNT_W'(1)) ? DONE : state;
  end
  always_ff @(posedge prog_clk) state <= pReset ? IDLE : state_d;
  // Valid bits stay MSB-aligned in sr, so the first word is pre-shifted past its pad bits.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr <= '0;
      sr_cnt <= '0;
      words_left <= '0;
      bits_left <= '0;
      tail_ones <= '0;
    end else if (!busy && start) begin
      sr <= '0;
      sr_cnt <= '0;
      words_left <= CNT_W'(NWORDS);
      bits_left <= CNT_W'(CHAIN_LEN);
      tail_ones <= '0;
    end else begin
      if (take) begin
        sr <= first ? cfg.cfg_word << PAD : cfg.cfg_word;
        sr_cnt <= first ? FIRST_CNT : FULL_CNT;
        words_left <= words_left - CNT_W'(1);
      end else if (chain_clk_en) begin
        sr <= sr << 1;
        sr_cnt <= sr_cnt - SW'(1);
      end
      if (chain_clk_en) begin
        bits_left <= bits_left - CNT_W'(1);
        tail_ones <= &tail_ones ? tail_ones : tail_ones + CNT_W'(ccff_tail);
      end
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed and randomized loads checked against a chain/bitstream model
module tb_ccff_bitstream_loader;
  localparam int W = 8;
  localparam int L = 10;
  localparam int CW = 16;
  localparam int NW = (L + W - 1) / W;
  localparam int PAD = NW * W - L;
  logic prog_clk = 0, pReset = 1, start = 0;
  logic ccff_tail, ccff_head, chain_clk_en, busy, done;
  logic [CW-1:0] tail_ones;
  int vectors = 0, miscompares = 0;
  ccff_bitstream_loader_if #(.WORD_W(W)) bus();
  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(L), .CNT_W(CW)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg(bus),
    .ccff_tail(ccff_tail), .ccff_head(ccff_head), .chain_clk_en(chain_clk_en),
    .busy(busy), .done(done), .tail_ones(tail_ones));
  always #5 prog_clk = ~prog_clk;
  // downstream chain: shifts ccff_head in at the bottom, oldest bit leaves as ccff_tail
  logic [L-1:0] chain, pre_val;
  logic pre_req = 0;
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk) chain <= pre_req ? pre_val : chain_clk_en ? {chain[L-2:0], ccff_head} : chain;
  int cyc = 0, en_cnt = 0, done_rises = 0, done_cyc = 0;
  logic done_q = 0;
  logic [L-1:0] heads = '0;
  always @(posedge prog_clk) cyc++;
  always @(negedge prog_clk) begin
    if (chain_clk_en) begin
      en_cnt++;
      heads = {heads[L-2:0], ccff_head};
    end
    if (done && !done_q) begin
      done_rises++;
      done_cyc = cyc;
    end
    done_q = done;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [W*NW-1:0] words, input logic [L-1:0] pre, input int gap, input bit mid_start);
    int e0, r0, s_cyc, k, lat, cp, eff;
    logic [L-1:0] stream;
    stream = words[L-1:0];
    eff = gap + int'(mid_start);
    lat = L + 1;
    for (int i = 1; i < NW; i++) begin
      cp = (i == 1) ? W - PAD : W;
      lat += (1 + eff - cp > 0) ? 1 + eff - cp : 0;
    end
    @(negedge prog_clk);
    pre_val = pre;
    pre_req = 1;
    @(negedge prog_clk);
    pre_req = 0;
    e0 = en_cnt;
    r0 = done_rises;
    start = 1;
    bus.cfg_valid = 1;
    bus.cfg_word = words[W*NW-1 -: W];
    @(negedge prog_clk);
    start = 0;
    s_cyc = cyc;
    check("busy_after_start", busy, 1);
    check("done_cleared_on_start", done, 0);
    for (int i = 0; i < NW; i++) begin
      if (i > 0) begin
        bus.cfg_valid = 0;
        repeat (gap) @(negedge prog_clk);
      end
      bus.cfg_word = words[W*(NW-i)-1 -: W];
      bus.cfg_valid = 1;
      k = 0;
      while (!bus.cfg_ready && k < 50) begin
        @(negedge prog_clk);
        k++;
      end
      check("accept_timeout", k < 50, 1);
      @(negedge prog_clk);
      if (mid_start && i == 0) begin
        start = 1;
        @(negedge prog_clk);
        start = 0;
      end
    end
    bus.cfg_word = 8'hC3;
    bus.cfg_valid = 1;
    k = 0;
    while (!done && k < 100) begin
      @(negedge prog_clk);
      k++;
    end
    check("done_timeout", k < 100, 1);
    check("busy_in_done", busy, 0);
    check("en_in_done", chain_clk_en, 0);
    check("ready_in_done", bus.cfg_ready, 0);
    @(negedge prog_clk);
    check("enable_count", en_cnt - e0, L);
    check("done_once", done_rises - r0, 1);
    check("latency", done_cyc - s_cyc, lat);
    check("head_stream", heads, stream);
    check("chain_contents", chain, stream);
    check("tail_ones", tail_ones, $countones(pre));
    check("done_level", done, 1);
    bus.cfg_valid = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int e0, k;
    logic [W*NW-1:0] rw;
    logic [L-1:0] rp;
    bus.cfg_valid = 1;
    bus.cfg_word = '0;
    repeat (3) @(negedge prog_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", chain_clk_en, 0);
    check("rst_ready", bus.cfg_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_tail_ones", tail_ones, 0);
    pReset = 0;
    bus.cfg_valid = 0;
    @(negedge prog_clk);
    check("idle_ready_ignores_valid", bus.cfg_ready, 0);
    do_load(16'hFF00, 10'h3FF, 0, 0);
    do_load(16'h5A3C, 10'h155, 5, 0);
    rw = 16'($urandom);
    rp = 10'($urandom);
    do_load(rw, rp, 0, 1);
    @(negedge prog_clk);
    pre_val = '1;
    pre_req = 1;
    @(negedge prog_clk);
    pre_req = 0;
    e0 = en_cnt;
    start = 1;
    bus.cfg_valid = 1;
    bus.cfg_word = 8'hFF;
    @(negedge prog_clk);
    start = 0;
    k = 0;
    while (en_cnt - e0 < 3 && k < 50) begin
      @(negedge prog_clk);
      k++;
    end
    check("midload_timeout", k < 50, 1);
    pReset = 1;
    @(negedge prog_clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_en", chain_clk_en, 0);
    check("abort_ready", bus.cfg_ready, 0);
    check("abort_tail_ones", tail_ones, 0);
    start = 1;
    @(negedge prog_clk);
    check("reset_beats_start", busy, 0);
    pReset = 0;
    start = 0;
    bus.cfg_valid = 0;
    do_load(16'hA5C3, 10'h0F0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      rw = 16'($urandom);
      rp = 10'($urandom);
      do_load(rw, rp, int'($urandom_range(0, 4)), n % 5 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
